// File: rtl/l2cache_nway_control.sv
// l2cache_nway_control: control FSM for an N-way write-back, write-allocate L2 cache
// with per-set tree pseudo-LRU, victim selection and bounded memory retries.
module l2cache_nway_control #(
  parameter int WAYS      = 4,
  parameter int SETS      = 8,
  parameter int RTY_LIMIT = 3,
  localparam int SB = $clog2(SETS),
  localparam int WB = $clog2(WAYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cyc,
  input  logic          cpu_stb,
  input  logic          cpu_we,
  output logic          cpu_ack,
  output logic          cpu_rty,
  input  logic [SB-1:0] set_idx,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-1:0] dirty_vec,
  output logic [WAYS-1:0] way_write,
  output logic [WAYS-1:0] valid_write,
  output logic          valid_in,
  output logic [WAYS-1:0] dirty_write,
  output logic          dirty_in,
  output logic [WB-1:0] victim_way,
  output logic          datainmux_sel,
  output logic          memaddrmux_sel,
  output logic          mem_cyc,
  output logic          mem_stb,
  output logic          mem_we,
  input  logic          mem_ack,
  input  logic          mem_rty
);
  typedef enum logic [2:0] {IDLE, WRBK, GAP, ALLOC, BACKOFF} state_t;
  localparam logic [WAYS-1:0] ONE = 1;
  state_t state_q, state_d, ret_q, ret_d;
  logic [3:0] cnt_q, cnt_d;
  logic [WB-1:0] victim_q, victim_d, hw, iw, vic, pl_way;
  logic rty_q, rty_d, pl_we, req, hit;
  logic [WAYS-2:0] plru_q [SETS];
  // Node bits on the path to way w are set to point away from w.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t, input logic [WB-1:0] w);
    int n, m;
    touch = t;
    n = 0;
    for (int l = WB - 1; l >= 0; l--) begin
      m = n;
      for (int k = 0; k < WAYS - 1; k++)
        if (k == n) begin
          touch[k] = ~w[l];
          m = 2 * n + 1 + int'(w[l]);
        end
      n = m;
    end
  endfunction
  function automatic logic [WB-1:0] pick(input logic [WAYS-2:0] t);
    int n, m;
    n = 0;
    for (int l = 0; l < WB; l++) begin
      m = n;
      for (int k = 0; k < WAYS - 1; k++)
        if (k == n) m = 2 * n + 1 + int'(t[k]);
      n = m;
    end
    pick = WB'(n - (WAYS - 1));
  endfunction
  assign req = cpu_cyc & cpu_stb;
  assign hit = |hit_vec;
  assign cpu_rty = rty_q;
  assign victim_way = victim_q;
  always_comb begin
    hw = '0;
    iw = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hw = WB'(i);
      if (!valid_vec[i]) iw = WB'(i);
    end
    vic = &valid_vec ? pick(plru_q[set_idx]) : iw;
  end
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    victim_d = victim_q;
    rty_d = 1'b0;
    pl_we = 1'b0;
    pl_way = '0;
    cpu_ack = 1'b0;
    way_write = '0;
    valid_write = '0;
    dirty_write = '0;
    valid_in = 1'b0;
    dirty_in = 1'b0;
    datainmux_sel = 1'b0;
    memaddrmux_sel = 1'b0;
    mem_cyc = 1'b0;
    mem_stb = 1'b0;
    mem_we = 1'b0;
    case (state_q)
      IDLE:
        if (req && hit) begin
          cpu_ack = 1'b1;
          pl_we = 1'b1;
          pl_way = hw;
          if (cpu_we) begin
            datainmux_sel = 1'b1;
            way_write = ONE << hw;
            valid_write = ONE << hw;
            dirty_write = ONE << hw;
            valid_in = 1'b1;
            dirty_in = 1'b1;
          end
        end else if (req) begin
          victim_d = vic;
          cnt_d = '0;
          state_d = (valid_vec[vic] && dirty_vec[vic]) ? WRBK : ALLOC;
        end
      WRBK, ALLOC: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_we = state_q == WRBK;
        memaddrmux_sel = state_q == WRBK;
        if (mem_ack && state_q == WRBK) begin
          cnt_d = '0;
          state_d = GAP;
        end else if (mem_ack) begin
          way_write = ONE << victim_q;
          valid_write = ONE << victim_q;
          dirty_write = ONE << victim_q;
          valid_in = 1'b1;
          pl_we = 1'b1;
          pl_way = victim_q;
          state_d = IDLE;
        end else if (mem_rty && cnt_q < 4'(RTY_LIMIT)) begin
          cnt_d = cnt_q + 4'd1;
          ret_d = state_q;
          state_d = BACKOFF;
        end else if (mem_rty) begin
          rty_d = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: state_d = ALLOC;
      BACKOFF: state_d = ret_q;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      cnt_q <= '0;
      victim_q <= '0;
      rty_q <= 1'b0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      victim_q <= victim_d;
      rty_q <= rty_d;
      if (pl_we) plru_q[set_idx] <= touch(plru_q[set_idx], pl_way);
    end
endmodule

// File: tb/tb_l2cache_nway_control.sv
// tb_l2cache_nway_control: directed bench for the L2 control FSM, expected
// values worked out by hand from the tree-PLRU and retry rules.
module tb_l2cache_nway_control;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_cyc = 0, cpu_stb = 0, cpu_we = 0, cpu_ack, cpu_rty;
  logic [2:0] set_idx = '0;
  logic [3:0] hit_vec = '0, valid_vec = '0, dirty_vec = '0;
  logic [3:0] way_write, valid_write, dirty_write;
  logic valid_in, dirty_in, datainmux_sel, memaddrmux_sel;
  logic [1:0] victim_way;
  logic mem_cyc, mem_stb, mem_we, mem_ack = 0, mem_rty = 0;
  int nvec = 0, nerr = 0;

  l2cache_nway_control #(.WAYS(4), .SETS(8), .RTY_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_rty(cpu_rty), .set_idx(set_idx), .hit_vec(hit_vec),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec), .way_write(way_write),
    .valid_write(valid_write), .valid_in(valid_in), .dirty_write(dirty_write),
    .dirty_in(dirty_in), .victim_way(victim_way), .datainmux_sel(datainmux_sel),
    .memaddrmux_sel(memaddrmux_sel), .mem_cyc(mem_cyc), .mem_stb(mem_stb),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rty(mem_rty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] s, input logic [3:0] h, input logic [3:0] v,
                       input logic [3:0] d, input logic we);
    cpu_cyc = 1; cpu_stb = 1; set_idx = s; hit_vec = h; valid_vec = v; dirty_vec = d; cpu_we = we;
  endtask

  task automatic idle_in();
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; hit_vec = '0;
  endtask

  task automatic hit(input logic [2:0] s, input logic [1:0] w, input logic we);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    drive(s, oh, 4'hf, 4'h0, we);
    #1;
    chk("hit_ack", cpu_ack, 1);
    chk("hit_writes", {way_write, valid_write, dirty_write, valid_in, dirty_in, datainmux_sel},
        we ? {oh, oh, oh, 3'b111} : 15'h0);
    nxt();
    idle_in();
  endtask

  task automatic miss_fill(input logic [2:0] s, input logic [3:0] v, input logic [1:0] exp_v);
    logic [3:0] oh;
    oh = 4'b0001 << exp_v;
    drive(s, 4'h0, v, 4'h0, 1'b0);
    #1;
    chk("miss_noack", {cpu_ack, mem_cyc}, 0);
    nxt();
    chk("fill_victim", victim_way, exp_v);
    chk("fill_bus", {mem_cyc, mem_stb, mem_we, memaddrmux_sel}, 4'b1100);
    mem_ack = 1;
    #1;
    chk("fill_writes", {way_write, valid_write, dirty_write, valid_in, dirty_in}, {oh, oh, oh, 2'b10});
    nxt();
    mem_ack = 0;
    hit_vec = oh;
    #1;
    chk("fill_ack", {cpu_ack, mem_cyc}, 2'b10);
    nxt();
    idle_in();
  endtask

  initial begin
    nxt();
    nxt();
    chk("reset_outs", {cpu_ack, cpu_rty, mem_cyc, mem_stb, mem_we, way_write, victim_way}, 0);
    rst = 0;
    nxt();
    // fills of set 2 land on ways 0..3 (lowest invalid)
    for (int w = 0; w < 4; w++) miss_fill(3'd2, 4'((1 << w) - 1), 2'(w));
    // hits 0,1,2 leave root->lower, node1->way0, so the tree picks way 0
    hit(3'd2, 2'd0, 0);
    hit(3'd2, 2'd1, 0);
    hit(3'd2, 2'd2, 0);
    miss_fill(3'd2, 4'hf, 2'd0);
    // hits 2,0,1 leave root->upper, node2->way3
    hit(3'd2, 2'd2, 0);
    hit(3'd2, 2'd0, 0);
    hit(3'd2, 2'd1, 0);
    miss_fill(3'd2, 4'hf, 2'd3);
    // write hit way1, then steer the tree to way1 and miss on a dirty victim
    hit(3'd2, 2'd1, 1);
    hit(3'd2, 2'd0, 0);
    hit(3'd2, 2'd2, 0);
    drive(3'd2, 4'h0, 4'hf, 4'b0010, 1'b0);
    nxt();
    chk("wb_bus", {mem_cyc, mem_stb, mem_we, memaddrmux_sel, victim_way}, 6'b111101);
    mem_ack = 1;
    #1;
    chk("wb_nowrite", {way_write, valid_write, dirty_write}, 0);
    nxt();
    mem_ack = 0;
    chk("gap_idle", {mem_cyc, mem_stb, mem_we}, 0);
    nxt();
    chk("alloc_bus", {mem_cyc, mem_stb, mem_we, memaddrmux_sel}, 4'b1100);
    mem_ack = 1;
    #1;
    chk("wb_fill", {way_write, dirty_write, valid_in, dirty_in}, 10'b0010_0010_10);
    nxt();
    mem_ack = 0;
    hit_vec = 4'b0010;
    #1;
    chk("wb_ack", cpu_ack, 1);
    nxt();
    idle_in();
    // two retries then ack; tree now points at way3
    drive(3'd2, 4'h0, 4'hf, 4'h0, 1'b0);
    nxt();
    for (int r = 0; r < 2; r++) begin
      mem_rty = 1;
      #1;
      chk("rty_nowrite", way_write, 0);
      nxt();
      mem_rty = 0;
      chk("backoff_idle", {mem_cyc, mem_stb}, 0);
      nxt();
      chk("alloc_again", {mem_cyc, mem_stb, victim_way}, 4'b1111);
    end
    mem_ack = 1;
    #1;
    chk("rty_fill", way_write, 4'b1000);
    nxt();
    mem_ack = 0;
    hit_vec = 4'b1000;
    #1;
    chk("rty_ack", cpu_ack, 1);
    nxt();
    idle_in();
    // four retries exceed the limit
    drive(3'd2, 4'h0, 4'hf, 4'h0, 1'b0);
    nxt();
    chk("lim_victim", victim_way, 0);
    for (int r = 0; r < 4; r++) begin
      mem_rty = 1;
      #1;
      chk("lim_nowrite", {way_write, valid_write, dirty_write}, 0);
      nxt();
      mem_rty = 0;
      chk("lim_rty", {cpu_rty, mem_cyc}, r == 3 ? 2'b10 : 2'b00);
      if (r < 3) nxt();
    end
    idle_in();
    nxt();
    chk("rty_pulse_end", {cpu_rty, mem_cyc}, 0);
    // tree of set 2 now picks way 2; reset in the middle of its writeback
    hit(3'd2, 2'd0, 0);
    drive(3'd2, 4'h0, 4'hf, 4'b0100, 1'b0);
    nxt();
    chk("pre_rst_wb", {mem_cyc, mem_we, victim_way}, 4'b1110);
    rst = 1;
    #1;
    chk("async_rst", {mem_cyc, mem_stb, mem_we, victim_way}, 0);
    idle_in();
    nxt();
    rst = 0;
    nxt();
    miss_fill(3'd5, 4'b0011, 2'd2);
    miss_fill(3'd2, 4'hf, 2'd0);
    // idle with no request
    for (int c = 0; c < 10; c++) begin
      nxt();
      chk("idle_quiet", {mem_cyc, mem_stb, cpu_ack, cpu_rty, way_write, victim_way}, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
